// File: rtl/kbd_lcd_sequencer.sv
// Turns buffered PS/2 set-2 scancodes into single-character writes on the LCD driver,
// tracking prefixes, shift and a one-line text cursor.
module kbd_lcd_sequencer #(
    parameter int NUM_CHARS  = 32,
    parameter int CHARNUM_W  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 codeValid,
    input  logic [7:0]           code,
    input  logic                 lcdBusy,
    output logic                 lcdWEn,
    output logic [CHARNUM_W-1:0] lcdCharNum,
    output logic [7:0]           lcdDIn,
    output logic [CHARNUM_W-1:0] cursor,
    output logic                 shiftActive,
    output logic                 overflow,
    output logic                 dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CHARNUM_W-1:0] LAST = CHARNUM_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {IDLE, DECODE, WRITE, CLEAR} state_t;

    state_t               state_q, state_d;
    logic [7:0]           fifo_q [FIFO_DEPTH];
    logic [7:0]           fifo_d [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]           code_q, code_d;
    logic                 ext_q, ext_d, brk_q, brk_d;
    logic                 shift_q, shift_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 dropped_q, dropped_d;
    logic                 pend_bs_q, pend_bs_d;
    logic                 we_q, we_d;
    logic [CHARNUM_W-1:0] char_q, char_d;
    logic [CHARNUM_W-1:0] cursor_q, cursor_d;
    logic [7:0]           din_q, din_d;
    logic                 fifo_empty, fifo_full, is_letter;
    logic [7:0]           key_ascii;

    // JIS keyboard map; zero marks a code with no printable character
    function automatic logic [7:0] jis_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: jis_ascii = "a";   8'h32: jis_ascii = "b";   8'h21: jis_ascii = "c";
            8'h23: jis_ascii = "d";   8'h24: jis_ascii = "e";   8'h2B: jis_ascii = "f";
            8'h34: jis_ascii = "g";   8'h33: jis_ascii = "h";   8'h43: jis_ascii = "i";
            8'h3B: jis_ascii = "j";   8'h42: jis_ascii = "k";   8'h4B: jis_ascii = "l";
            8'h3A: jis_ascii = "m";   8'h31: jis_ascii = "n";   8'h44: jis_ascii = "o";
            8'h4D: jis_ascii = "p";   8'h15: jis_ascii = "q";   8'h2D: jis_ascii = "r";
            8'h1B: jis_ascii = "s";   8'h2C: jis_ascii = "t";   8'h3C: jis_ascii = "u";
            8'h2A: jis_ascii = "v";   8'h1D: jis_ascii = "w";   8'h22: jis_ascii = "x";
            8'h35: jis_ascii = "y";   8'h1A: jis_ascii = "z";
            8'h45: jis_ascii = "0";   8'h16: jis_ascii = "1";   8'h1E: jis_ascii = "2";
            8'h26: jis_ascii = "3";   8'h25: jis_ascii = "4";   8'h2E: jis_ascii = "5";
            8'h36: jis_ascii = "6";   8'h3D: jis_ascii = "7";   8'h3E: jis_ascii = "8";
            8'h46: jis_ascii = "9";   8'h29: jis_ascii = " ";
            8'h4E: jis_ascii = "-";   8'h55: jis_ascii = "^";   8'h6A: jis_ascii = 8'h5C;
            8'h54: jis_ascii = "@";   8'h5B: jis_ascii = "[";   8'h4C: jis_ascii = ";";
            8'h52: jis_ascii = ":";   8'h5D: jis_ascii = "]";   8'h41: jis_ascii = ",";
            8'h49: jis_ascii = ".";   8'h4A: jis_ascii = "/";
            default: jis_ascii = 8'h00;
        endcase
    endfunction

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign key_ascii  = jis_ascii(code_q);
    assign is_letter  = (key_ascii >= "a") && (key_ascii <= "z");

    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        code_d     = code_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        shift_d    = shift_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        pend_bs_d  = pend_bs_q;
        we_d       = we_q;
        char_d     = char_q;
        cursor_d   = cursor_q;
        din_d      = din_q;

        // Fullness is judged before any same-cycle pop, so a full FIFO always drops
        if (codeValid) begin
            if (fifo_full) begin
                dropped_d = 1'b1;
            end else begin
                fifo_d[wr_ptr_q[AW-1:0]] = code;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    code_d   = fifo_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (code_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (code_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (ext_q) begin
                        state_d = IDLE;
                    end else if (code_q == 8'h12 || code_q == 8'h59) begin
                        shift_d = !brk_q;
                    end else if (brk_q) begin
                        state_d = IDLE;
                    end else if (code_q == 8'h66) begin
                        if (cursor_q != '0) begin
                            we_d      = 1'b1;
                            char_d    = cursor_q - CHARNUM_W'(1);
                            din_d     = 8'h20;
                            pend_bs_d = 1'b1;
                            state_d   = WRITE;
                        end
                    end else if (code_q == 8'h5A) begin
                        we_d    = 1'b1;
                        char_d  = '0;
                        din_d   = 8'h20;
                        state_d = CLEAR;
                    end else if (key_ascii != 8'h00) begin
                        if (full_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            we_d      = 1'b1;
                            char_d    = cursor_q;
                            din_d     = (shift_q && is_letter) ? key_ascii - 8'h20 : key_ascii;
                            pend_bs_d = 1'b0;
                            state_d   = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (!lcdBusy) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                    if (pend_bs_q) begin
                        cursor_d   = char_q;
                        full_d     = 1'b0;
                        overflow_d = 1'b0;
                    end else if (cursor_q == LAST) begin
                        full_d = 1'b1;
                    end else begin
                        cursor_d = cursor_q + CHARNUM_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (!lcdBusy) begin
                    if (char_q == LAST) begin
                        we_d       = 1'b0;
                        state_d    = IDLE;
                        cursor_d   = '0;
                        full_d     = 1'b0;
                        overflow_d = 1'b0;
                    end else begin
                        char_d = char_q + CHARNUM_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            shift_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            pend_bs_q  <= 1'b0;
            we_q       <= 1'b0;
            char_q     <= '0;
            cursor_q   <= '0;
            din_q      <= 8'h20;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            shift_q    <= shift_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            pend_bs_q  <= pend_bs_d;
            we_q       <= we_d;
            char_q     <= char_d;
            cursor_q   <= cursor_d;
            din_q      <= din_d;
        end
    end

    assign lcdWEn      = we_q;
    assign lcdCharNum  = char_q;
    assign lcdDIn      = din_q;
    assign cursor      = cursor_q;
    assign shiftActive = shift_q;
    assign overflow    = overflow_q;
    assign dropped     = dropped_q;
endmodule

// File: tb/tb_kbd_lcd_sequencer.sv
// Bench for kbd_lcd_sequencer: a line-of-text model predicts every LCD write and the
// final cursor/flag state; directed scenarios pin the model with literal values.
module tb_kbd_lcd_sequencer;
    localparam int NUM_CHARS = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       codeValid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       lcdBusy = 1'b0;
    logic       lcdWEn;
    logic [4:0] lcdCharNum;
    logic [7:0] lcdDIn;
    logic [4:0] cursor;
    logic       shiftActive, overflow, dropped;

    kbd_lcd_sequencer dut (
        .clk(clk), .reset(reset), .codeValid(codeValid), .code(code), .lcdBusy(lcdBusy),
        .lcdWEn(lcdWEn), .lcdCharNum(lcdCharNum), .lcdDIn(lcdDIn), .cursor(cursor),
        .shiftActive(shiftActive), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int accept_count = 0;
    int base;
    logic [15:0] exp_q[$];
    logic [15:0] cmp_e;
    logic [4:0]  last_cn;
    logic [7:0]  last_din;
    bit          prev_stall = 0;
    logic [4:0]  held_cn;
    logic [7:0]  held_din;
    bit          busy_rand_en = 0;

    // Model state: number of characters on the line plus the key-state flags
    int m_n;
    bit m_ovf, m_shift, m_ext, m_brk, m_dropped;

    string keys = "abcdefghijklmnopqrstuvwxyz0123456789 -^|@[;:],./";
    logic [7:0] key_codes [48] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29,
        8'h4E, 8'h55, 8'h6A, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h5D, 8'h41, 8'h49, 8'h4A
    };
    logic [7:0] pool [28] = '{
        8'h1C, 8'h32, 8'h21, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h4E, 8'h55, 8'h6A, 8'h54, 8'h4A, 8'h41, 8'h52,
        8'h12, 8'h59, 8'h12, 8'hE0, 8'hF0, 8'hF0, 8'h66, 8'h66, 8'h5A, 8'h76, 8'h05, 8'h2B, 8'h3B, 8'h5D
    };

    function automatic logic [7:0] lookup(input logic [7:0] c);
        for (int i = 0; i < 48; i++)
            if (key_codes[i] == c) return (c == 8'h6A) ? 8'h5C : keys[i];
        return 8'h00;
    endfunction

    function automatic int model_cursor();
        return (m_n > NUM_CHARS - 1) ? NUM_CHARS - 1 : m_n;
    endfunction

    function automatic void model_code(input logic [7:0] c);
        bit e, b;
        logic [7:0] a;
        int cur;
        if (c == 8'hE0) begin m_ext = 1; return; end
        if (c == 8'hF0) begin m_brk = 1; return; end
        e = m_ext; b = m_brk; m_ext = 0; m_brk = 0;
        if (e) return;
        if (c == 8'h12 || c == 8'h59) begin m_shift = !b; return; end
        if (b) return;
        if (c == 8'h66) begin
            cur = model_cursor();
            if (cur > 0) begin
                exp_q.push_back({8'(cur - 1), 8'h20});
                m_n = cur - 1;
                m_ovf = 0;
            end
        end else if (c == 8'h5A) begin
            for (int i = 0; i < NUM_CHARS; i++) exp_q.push_back({8'(i), 8'h20});
            m_n = 0;
            m_ovf = 0;
        end else begin
            a = lookup(c);
            if (a == 8'h00) return;
            if (m_n == NUM_CHARS) begin
                m_ovf = 1;
            end else begin
                if (m_shift && a >= "a" && a <= "z") a = a - 8'h20;
                exp_q.push_back({8'(m_n), a});
                m_n++;
            end
        end
    endfunction

    // Every accepted write must be the next predicted one; a stalled request must hold still
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!lcdWEn || lcdCharNum != held_cn || lcdDIn != held_din) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got wen=%0b cn=%0d din=0x%0h, required wen=1 cn=%0d din=0x%0h",
                             lcdWEn, lcdCharNum, lcdDIn, held_cn, held_din);
                end
            end
            if (lcdWEn && !lcdBusy) begin
                accept_count++;
                last_cn  = lcdCharNum;
                last_din = lcdDIn;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got cn=%0d din=0x%0h, required no write", lcdCharNum, lcdDIn);
                end else begin
                    cmp_e = exp_q.pop_front();
                    if ({3'b000, lcdCharNum} != cmp_e[15:8] || lcdDIn != cmp_e[7:0]) begin
                        errors++;
                        $display("[TB] FAIL write: got cn=%0d din=0x%0h, required cn=%0d din=0x%0h",
                                 lcdCharNum, lcdDIn, cmp_e[15:8], cmp_e[7:0]);
                    end
                end
            end
            prev_stall = lcdWEn && lcdBusy;
            held_cn    = lcdCharNum;
            held_din   = lcdDIn;
        end
    end

    always @(posedge clk) begin
        #1;
        if (busy_rand_en) lcdBusy = ($urandom_range(0, 9) < 3);
    end

    task automatic checkLit(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkLit({tag, "_cursor"}, cursor, model_cursor());
        checkLit({tag, "_overflow"}, overflow, m_ovf);
        checkLit({tag, "_shift"}, shiftActive, m_shift);
        checkLit({tag, "_dropped"}, dropped, m_dropped);
        checkLit({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    // Caller sits just after a rising edge; the strobe lasts exactly one cycle
    task automatic applyStimulus(input logic [7:0] c);
        codeValid = 1'b1;
        code = c;
        model_code(c);
        @(posedge clk); #1;
        codeValid = 1'b0;
    endtask

    task automatic typeKey(input logic [7:0] c);
        applyStimulus(c);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic waitQuiet(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!lcdWEn) quiet++; else quiet = 0;
        end
        if (quiet < 10) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got busy after %0d cycles, required idle", tag, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic waitWEn(input string tag);
        int n = 0;
        while (!lcdWEn && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkLit({tag, "_wen_rise"}, lcdWEn, 1);
    endtask

    task automatic doReset();
        codeValid = 1'b0;
        lcdBusy = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_n = 0; m_ovf = 0; m_shift = 0; m_ext = 0; m_brk = 0; m_dropped = 0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ov [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        doReset();
        checkLit("rst_wen", lcdWEn, 0);
        checkLit("rst_charnum", lcdCharNum, 0);
        checkLit("rst_din", lcdDIn, 8'h20);
        checkLit("rst_cursor", cursor, 0);
        checkLit("rst_shift", shiftActive, 0);
        checkLit("rst_overflow", overflow, 0);
        checkLit("rst_dropped", dropped, 0);

        $display("[TB] single key");
        base = accept_count;
        typeKey(8'h1C);
        waitQuiet("single");
        checkLit("single_writes", accept_count - base, 1);
        checkLit("single_cn", last_cn, 0);
        checkLit("single_din", last_din, 8'h61);
        checkLit("single_cursor", cursor, 1);
        base = accept_count;
        typeKey(8'hF0); typeKey(8'h1C);
        waitQuiet("break");
        checkLit("break_writes", accept_count - base, 0);
        checkOutput("single");

        $display("[TB] shift");
        doReset();
        base = accept_count;
        typeKey(8'h12); typeKey(8'h1C);
        waitQuiet("shift1");
        checkLit("shift_upper_din", last_din, 8'h41);
        checkLit("shift_upper_cn", last_cn, 0);
        checkLit("shift_held", shiftActive, 1);
        typeKey(8'hE0); typeKey(8'hF0); typeKey(8'h12);
        waitQuiet("shift_ext");
        checkLit("shift_ext_unchanged", shiftActive, 1);
        typeKey(8'hF0); typeKey(8'h12); typeKey(8'h1C);
        waitQuiet("shift2");
        checkLit("shift_released", shiftActive, 0);
        checkLit("shift_lower_din", last_din, 8'h61);
        checkLit("shift_lower_cn", last_cn, 1);
        checkLit("shift_writes", accept_count - base, 2);
        typeKey(8'hE0); typeKey(8'h12);
        waitQuiet("shift3");
        checkLit("shift_e012", shiftActive, 0);
        checkOutput("shift");

        $display("[TB] backspace");
        doReset();
        base = accept_count;
        typeKey(8'h1C); typeKey(8'h32); typeKey(8'h66);
        waitQuiet("bs");
        checkLit("bs_writes", accept_count - base, 3);
        checkLit("bs_cn", last_cn, 1);
        checkLit("bs_din", last_din, 8'h20);
        checkLit("bs_cursor", cursor, 1);
        typeKey(8'h66);
        waitQuiet("bs0");
        checkLit("bs_cursor0", cursor, 0);
        base = accept_count;
        typeKey(8'h66);
        waitQuiet("bs_none");
        checkLit("bs_at_zero_writes", accept_count - base, 0);
        checkOutput("bs");

        $display("[TB] full line and enter");
        doReset();
        base = accept_count;
        for (int i = 0; i < 33; i++) typeKey(8'h1C);
        waitQuiet("full");
        checkLit("full_writes", accept_count - base, 32);
        checkLit("full_overflow", overflow, 1);
        checkLit("full_cursor", cursor, 31);
        base = accept_count;
        typeKey(8'h5A);
        waitQuiet("enter");
        checkLit("enter_writes", accept_count - base, 32);
        checkLit("enter_last_cn", last_cn, 31);
        checkLit("enter_last_din", last_din, 8'h20);
        checkLit("enter_cursor", cursor, 0);
        checkLit("enter_overflow", overflow, 0);
        checkOutput("enter");

        $display("[TB] stall");
        doReset();
        base = accept_count;
        lcdBusy = 1'b1;
        applyStimulus(8'h1C);
        waitWEn("stall");
        repeat (5) @(negedge clk);
        checkLit("stall_wen", lcdWEn, 1);
        checkLit("stall_cn", lcdCharNum, 0);
        checkLit("stall_din", lcdDIn, 8'h61);
        @(posedge clk); #1;
        lcdBusy = 1'b0;
        waitQuiet("stall");
        checkLit("stall_writes", accept_count - base, 1);
        checkOutput("stall");

        $display("[TB] fifo overflow");
        doReset();
        base = accept_count;
        lcdBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            codeValid = 1'b1;
            code = ov[i];
            if (i < 5) model_code(ov[i]);
            @(posedge clk); #1;
        end
        codeValid = 1'b0;
        m_dropped = 1;
        checkLit("ovf_dropped", dropped, 1);
        checkLit("ovf_held_wen", lcdWEn, 1);
        checkLit("ovf_held_din", lcdDIn, 8'h61);
        lcdBusy = 1'b0;
        waitQuiet("ovf");
        checkLit("ovf_writes", accept_count - base, 5);
        checkLit("ovf_last_cn", last_cn, 4);
        checkLit("ovf_last_din", last_din, 8'h65);
        checkOutput("ovf");

        $display("[TB] reset during write");
        doReset();
        lcdBusy = 1'b1;
        applyStimulus(8'h1C);
        waitWEn("rstw");
        #2;
        reset = 1'b1;
        #1;
        checkLit("async_wen_fall", lcdWEn, 0);
        @(posedge clk); #1;
        doReset();
        checkOutput("rstw");

        $display("[TB] random bursts");
        busy_rand_en = 1;
        for (int b = 0; b < 80; b++) begin
            int n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) applyStimulus(pool[$urandom_range(0, 27)]);
            waitQuiet("rand");
            checkOutput("rand");
        end
        busy_rand_en = 0;
        @(posedge clk); #1;
        lcdBusy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
